// File: rtl/storage_server.sv
// Storage-side request server: queues {core_id, addr} requests, reads a fixed-latency
// memory in order, and broadcasts {core_id, data} with a one-cycle txn_done strobe.
module storage_server #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             storage_valid,
    input  logic [ID_WIDTH+ADDR_WIDTH-1:0]   number_and_addr,
    output logic                             fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             overflow,
    output logic                             busy,
    output logic                             mem_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]   data_from_storage,
    output logic                             txn_done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REQ_W = ID_WIDTH + ADDR_WIDTH;
    localparam int unsigned RSP_W = ID_WIDTH + DATA_WIDTH;
    localparam int unsigned LAT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [REQ_W-1:0]        fifo_mem_q [FIFO_DEPTH];
    logic [REQ_W-1:0]        fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
    logic                    fifo_full_q, fifo_full_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q, busy_d;
    logic                    mem_en_q, mem_en_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [ID_WIDTH-1:0]     core_id_q, core_id_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic [RSP_W-1:0]        data_q, data_d;
    logic                    txn_done_q, txn_done_d;
    logic                    wr_en, pop;
    logic [REQ_W-1:0]        head;

    // Request FIFO; full is taken from the registered flag, so a same-cycle pop never frees space
    always_comb begin
        wr_en        = storage_valid && !fifo_full_q;
        pop          = (state_q == IDLE) && (fifo_count_q != '0);
        head         = fifo_mem_q[rd_ptr_q];
        fifo_mem_d   = fifo_mem_q;
        if (wr_en) begin
            fifo_mem_d[wr_ptr_q] = number_and_addr;
        end
        wr_ptr_d     = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_count_d = fifo_count_q + CNT_W'(wr_en) - CNT_W'(pop);
        fifo_full_d  = (fifo_count_d == CNT_W'(FIFO_DEPTH));
        overflow_d   = overflow_q || (storage_valid && fifo_full_q);
    end

    // Serve FSM: IDLE pops, ISSUE strobes the memory, WAIT counts latency, RESP strobes done
    always_comb begin
        state_d    = state_q;
        mem_en_d   = 1'b0;
        txn_done_d = 1'b0;
        mem_addr_d = mem_addr_q;
        core_id_d  = core_id_q;
        lat_cnt_d  = lat_cnt_q;
        data_d     = data_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    core_id_d  = head[REQ_W-1 -: ID_WIDTH];
                    mem_addr_d = head[ADDR_WIDTH-1:0];
                    mem_en_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_W'(RD_LATENCY - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    data_d     = {core_id_q, mem_rdata};
                    txn_done_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            fifo_full_q  <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            core_id_q    <= '0;
            lat_cnt_q    <= '0;
            data_q       <= '0;
            txn_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            fifo_full_q  <= fifo_full_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            core_id_q    <= core_id_d;
            lat_cnt_q    <= lat_cnt_d;
            data_q       <= data_d;
            txn_done_q   <= txn_done_d;
        end
    end

    assign fifo_full         = fifo_full_q;
    assign fifo_count        = fifo_count_q;
    assign overflow          = overflow_q;
    assign busy              = busy_q;
    assign mem_en            = mem_en_q;
    assign mem_addr          = mem_addr_q;
    assign data_from_storage = data_q;
    assign txn_done          = txn_done_q;

endmodule

// File: tb/tb_storage_server.sv
// Bench for storage_server: three instances (read latency 1, 3, 7), each with its own
// pipelined memory model that returns junk outside the exact read-latency slot.
module tb_storage_server;

    localparam logic [31:0] JUNK = 32'hBAD0_0BAD;

    logic        clk, rst_n;
    logic [11:0] nad;
    logic        sv1, sv3, sv7;
    logic [31:0] mem_arr [256];

    logic        full1, ovf1, busy1, en1, done1;
    logic [3:0]  cnt1;
    logic [7:0]  addr1;
    logic [35:0] data1;
    logic [31:0] rdata1;
    logic        full3, ovf3, busy3, en3, done3;
    logic [3:0]  cnt3;
    logic [7:0]  addr3;
    logic [35:0] data3;
    logic [31:0] rdata3;
    logic        full7, ovf7, busy7, en7, done7;
    logic [3:0]  cnt7;
    logic [7:0]  addr7;
    logic [35:0] data7;
    logic [31:0] rdata7;

    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];
    logic [31:0] pipe7 [7];

    int n_cmp = 0;
    int n_err = 0;

    storage_server #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .storage_valid(sv1), .number_and_addr(nad),
        .fifo_full(full1), .fifo_count(cnt1), .overflow(ovf1), .busy(busy1),
        .mem_en(en1), .mem_addr(addr1), .mem_rdata(rdata1),
        .data_from_storage(data1), .txn_done(done1));

    storage_server #(.RD_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .storage_valid(sv3), .number_and_addr(nad),
        .fifo_full(full3), .fifo_count(cnt3), .overflow(ovf3), .busy(busy3),
        .mem_en(en3), .mem_addr(addr3), .mem_rdata(rdata3),
        .data_from_storage(data3), .txn_done(done3));

    storage_server #(.RD_LATENCY(7)) u_l7 (
        .clk(clk), .rst_n(rst_n), .storage_valid(sv7), .number_and_addr(nad),
        .fifo_full(full7), .fifo_count(cnt7), .overflow(ovf7), .busy(busy7),
        .mem_en(en7), .mem_addr(addr7), .mem_rdata(rdata7),
        .data_from_storage(data7), .txn_done(done7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data valid exactly L cycles after the edge that samples mem_en
    always @(posedge clk) begin
        pipe1    <= en1 ? mem_arr[addr1] : JUNK;
        pipe3[0] <= en3 ? mem_arr[addr3] : JUNK;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        pipe7[0] <= en7 ? mem_arr[addr7] : JUNK;
        for (int i = 1; i < 7; i++) pipe7[i] <= pipe7[i-1];
    end
    assign rdata1 = pipe1;
    assign rdata3 = pipe3[2];
    assign rdata7 = pipe7[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sv1 = 1'b0; sv3 = 1'b0; sv7 = 1'b0; nad = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [31:0] mval(input logic [7:0] a);
        return (a == 8'h3C) ? 32'hDEADBEEF : {24'hC0DE00, a};
    endfunction

    typedef struct {
        logic        sv;
        logic [11:0] nad;
        logic        en;
        logic [7:0]  addr;
        logic        done;
        logic        bsy;
        logic [3:0]  cnt;
        logic [35:0] data;
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        logic [11:0] burst [4];
        int          maxc, cyc, nresp, first;
        logic        exp_done, saw;

        for (int i = 0; i < 256; i++) mem_arr[i] = mval(8'(i));
        vecs[0] = '{1'b1, 12'h13C, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 36'h0};
        vecs[1] = '{1'b0, 12'h000, 1'b1, 8'h3C, 1'b0, 1'b1, 4'd0, 36'h0};
        vecs[2] = '{1'b0, 12'h000, 1'b0, 8'h3C, 1'b0, 1'b1, 4'd0, 36'h0};
        vecs[3] = '{1'b0, 12'h000, 1'b0, 8'h3C, 1'b1, 1'b1, 4'd0, 36'h1DEADBEEF};
        vecs[4] = '{1'b0, 12'h000, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd0, 36'h1DEADBEEF};
        vecs[5] = '{1'b0, 12'h000, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd0, 36'h1DEADBEEF};
        vecs[6] = '{1'b0, 12'h000, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd0, 36'h1DEADBEEF};
        burst = '{12'h100, 12'h201, 12'h402, 12'h803};

        sv1 = 1'b0; sv3 = 1'b0; sv7 = 1'b0; nad = '0;
        rst_n = 1'b0;
        step();
        chk("reset_outputs", {full1, cnt1, ovf1, busy1, en1, addr1, done1}, '0);
        chk("reset_data", 64'(data1), 64'h0);
        rst_n = 1'b1;
        step();

        // Single request, table-driven: row k inputs in cycle k, outputs seen in cycle k+1
        for (int k = 0; k < 7; k++) begin
            sv1 = vecs[k].sv;
            nad = vecs[k].nad;
            step();
            chk($sformatf("single_en[%0d]", k),   64'(en1),    64'(vecs[k].en));
            chk($sformatf("single_addr[%0d]", k), 64'(addr1),  64'(vecs[k].addr));
            chk($sformatf("single_done[%0d]", k), 64'(done1),  64'(vecs[k].done));
            chk($sformatf("single_busy[%0d]", k), 64'(busy1),  64'(vecs[k].bsy));
            chk($sformatf("single_cnt[%0d]", k),  64'(cnt1),   64'(vecs[k].cnt));
            chk($sformatf("single_data[%0d]", k), 64'(data1),  64'(vecs[k].data));
        end

        // Ordered burst of four: responses every 4 cycles in FIFO order
        do_reset();
        maxc = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) begin sv1 = 1'b1; nad = burst[c]; end
            else sv1 = 1'b0;
            step();
            cyc = c + 1;
            exp_done = (cyc % 4 == 0) && (cyc >= 4) && (cyc <= 16);
            chk($sformatf("burst_done[c%0d]", cyc), 64'(done1), 64'(exp_done));
            if (exp_done)
                chk($sformatf("burst_data[c%0d]", cyc), 64'(data1),
                    64'({burst[cyc/4-1][11:8], mval(burst[cyc/4-1][7:0])}));
            if (int'(cnt1) > maxc) maxc = int'(cnt1);
        end
        chk("burst_peak_count", 64'(maxc), 64'd3);

        // Overflow with latency 7: ten back-to-back writes, the tenth dropped
        do_reset();
        nresp = 0;
        for (int c = 0; c < 110; c++) begin
            if (c < 10) begin sv7 = 1'b1; nad = {4'(c), 8'(8'h10 + c)}; end
            else sv7 = 1'b0;
            step();
            cyc = c + 1;
            if (cyc == 8)  chk("ovf_full_c8", 64'(full7), 64'd0);
            if (cyc == 9)  chk("ovf_full_c9", 64'(full7), 64'd1);
            if (cyc == 9)  chk("ovf_flag_c9", 64'(ovf7), 64'd0);
            if (cyc == 10) chk("ovf_flag_c10", 64'(ovf7), 64'd1);
            if (done7) begin
                chk($sformatf("ovf_resp[%0d]", nresp), 64'(data7),
                    64'({4'(nresp), mval(8'(8'h10 + nresp))}));
                nresp++;
            end
        end
        chk("ovf_resp_count", 64'(nresp), 64'd9);
        chk("ovf_sticky", 64'(ovf7), 64'd1);

        // Write and pop in the same cycle with two entries held
        do_reset();
        for (int c = 0; c < 7; c++) begin
            sv1 = (c == 0 || c == 2 || c == 3 || c == 5);
            nad = {4'h5, 8'(c)};
            step();
            cyc = c + 1;
            if (cyc == 4 || cyc == 5 || cyc == 6)
                chk($sformatf("wrpop_cnt[c%0d]", cyc), 64'(cnt1), 64'd2);
        end

        // Write and pop in the same cycle while full: write dropped, overflow set
        do_reset();
        for (int c = 0; c < 12; c++) begin
            sv7 = (c == 0) || (c >= 2 && c <= 9) || (c == 11);
            nad = {4'h6, 8'(c)};
            step();
            cyc = c + 1;
            if (cyc == 11) chk("fullpop_state_c11", 64'({full7, ovf7, cnt7}), 64'({1'b1, 1'b0, 4'd8}));
            if (cyc == 12) chk("fullpop_state_c12", 64'({full7, ovf7, cnt7}), 64'({1'b0, 1'b1, 4'd7}));
        end

        // Asynchronous reset in WAIT: outputs clear at once, no stray response
        do_reset();
        for (int c = 0; c < 4; c++) begin
            sv7 = (c < 2);
            nad = {4'h7, 8'h20};
            step();
        end
        chk("rst_pre_busy", 64'({busy7, cnt7, addr7}), 64'({1'b1, 4'd1, 8'h20}));
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_clear", 64'({full7, cnt7, ovf7, busy7, en7, addr7, done7}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done7 || busy7) saw = 1'b1;
        end
        chk("rst_no_stray_txn", 64'(saw), 64'd0);
        first = -1;
        for (int c = 0; c < 14; c++) begin
            sv7 = (c == 0);
            nad = 12'h93C;
            step();
            if (done7 && first < 0) first = c + 1;
        end
        chk("rst_after_latency", 64'(first), 64'd10);
        chk("rst_after_data", 64'(data7), 64'h9DEADBEEF);

        // Latency 3: done in c0+6 with data from the exact latency slot
        do_reset();
        first = -1;
        for (int c = 0; c < 10; c++) begin
            sv3 = (c == 0);
            nad = 12'h33C;
            step();
            if (done3 && first < 0) first = c + 1;
        end
        chk("lat3_done_cycle", 64'(first), 64'd6);
        chk("lat3_data", 64'(data3), 64'h3DEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
